// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package mod_n_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_enable_prescaler.sv
// Divides the enable strobe by PRESCALE: tick fires on every PRESCALE-th enabled cycle.
module mod_n_updown_counter_enable_prescaler
  import mod_n_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  // With PRESCALE=1 the counter is stuck at 0 and tick degenerates to enable.
  localparam int CNT_W = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, prescaled enable and
// optional saturation; wrap and sat are registered alongside the count.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic             SAT_MODE = (SATURATE == MODE_SAT);

  logic             tick;
  logic             restart;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  assign restart = clear | load;

  mod_n_updown_counter_enable_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .restart(restart),
    .tick   (tick)
  );

  // Candidate value for a count step, including boundary wrap/hold handling.
  always_comb begin
    load_clamped = ({1'b0, load_value} >= MOD_EXT) ? MAX_V : load_value;
    step_val     = out_q;
    step_wrap    = 1'b0;
    if (up == DIR_UP) begin
      if (out_q == MAX_V) begin
        if (!SAT_MODE) begin
          step_val  = ZERO;
          step_wrap = 1'b1;
        end
      end else begin
        step_val = out_q + ONE;
      end
    end else begin
      if (out_q == ZERO) begin
        if (!SAT_MODE) begin
          step_val  = MAX_V;
          step_wrap = 1'b1;
        end
      end else begin
        step_val = out_q - ONE;
      end
    end
  end

  // Priority: clear > load > step > hold; sat follows the next count and direction.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (clear) begin
      out_d = ZERO;
    end else if (load) begin
      out_d = load_clamped;
    end else if (tick) begin
      out_d  = step_val;
      wrap_d = step_wrap;
    end
    sat_d = !clear && SAT_MODE &&
            (((out_d == MAX_V) && (up == DIR_UP)) ||
             ((out_d == ZERO) && (up == DIR_DOWN)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter: four configurations share one stimulus stream
// and are checked every cycle against an integer model plus directed literals.
module tb_mod_n_updown_counter;

  localparam int NI = 4;
  localparam int MODS [NI] = '{8, 10, 5, 8};
  localparam int PRES [NI] = '{1, 1, 1, 3};
  localparam int SATS [NI] = '{0, 0, 1, 0};
  localparam int WIDS [NI] = '{3, 4, 3, 3};

  typedef struct {
    int o;
    int p;
    int w;
    int s;
  } mst_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] lv;

  logic [2:0] out0, out2, out3;
  logic [3:0] out1;
  logic       wrap0, wrap1, wrap2, wrap3;
  logic       sat0, sat1, sat2, sat3;

  int   total;
  int   bad;
  logic chk_en;
  mst_t m_st [NI];

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(1), .SATURATE(0)) u_d0 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(lv[2:0]), .out(out0), .wrap(wrap0), .sat(sat0));
  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(lv), .out(out1), .wrap(wrap1), .sat(sat1));
  mod_n_updown_counter #(.WIDTH(3), .MODULUS(5), .PRESCALE(1), .SATURATE(1)) u_d2 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(lv[2:0]), .out(out2), .wrap(wrap2), .sat(sat2));
  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE(3), .SATURATE(0)) u_d3 (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .load_value(lv[2:0]), .out(out3), .wrap(wrap3), .sat(sat3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Next state from the counting rules, using plain modular integer arithmetic.
  function automatic mst_t model_next(input int i);
    mst_t r;
    int   m, v, o;
    m   = MODS[i];
    o   = m_st[i].o;
    r   = m_st[i];
    r.w = 0;
    if (clear) begin
      r.o = 0; r.p = 0; r.s = 0;
      return r;
    end
    if (load) begin
      v   = int'(lv) % (1 << WIDS[i]);
      r.o = (v >= m) ? m - 1 : v;
      r.p = 0;
    end else if (enable) begin
      if (m_st[i].p == PRES[i] - 1) begin
        r.p = 0;
        if (SATS[i] != 0) begin
          r.o = up ? ((o < m - 1) ? o + 1 : o) : ((o > 0) ? o - 1 : o);
        end else begin
          r.o = (o + (up ? 1 : m - 1)) % m;
          r.w = up ? int'(o == m - 1) : int'(o == 0);
        end
      end else begin
        r.p = m_st[i].p + 1;
      end
    end
    r.s = int'((SATS[i] != 0) && (((r.o == m - 1) && up) || ((r.o == 0) && !up)));
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) m_st[i] <= '{0, 0, 0, 0};
    end else begin
      for (int i = 0; i < NI; i++) m_st[i] <= model_next(i);
    end
  end

  function automatic int dut_out(input int i);
    case (i)
      0: return int'(out0);
      1: return int'(out1);
      2: return int'(out2);
      default: return int'(out3);
    endcase
  endfunction

  function automatic int dut_wrap(input int i);
    case (i)
      0: return int'(wrap0);
      1: return int'(wrap1);
      2: return int'(wrap2);
      default: return int'(wrap3);
    endcase
  endfunction

  function automatic int dut_sat(input int i);
    case (i)
      0: return int'(sat0);
      1: return int'(sat1);
      2: return int'(sat2);
      default: return int'(sat3);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("model out[%0d]", i), dut_out(i), m_st[i].o);
        check($sformatf("model wrap[%0d]", i), dut_wrap(i), m_st[i].w);
        check($sformatf("model sat[%0d]", i), dut_sat(i), m_st[i].s);
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    reset  = 1'b0;
    enable = 1'b0;
    up     = 1'b1;
    clear  = 1'b0;
    load   = 1'b0;
    lv     = 4'd0;
    step(2);
    check("reset out0", int'(out0), 0);
    check("reset wrap0", int'(wrap0), 0);
    check("reset sat2", int'(sat2), 0);

    // Count up from reset through a full wrap.
    reset  = 1'b1;
    enable = 1'b1;
    chk_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check($sformatf("up out0 k=%0d", k), int'(out0), k % 8);
      check($sformatf("up wrap0 k=%0d", k), int'(wrap0), (k == 8) ? 1 : 0);
    end
    check("sat hold out2", int'(out2), 4);
    check("sat hold sat2", int'(sat2), 1);

    // Reverse at 0: underflow wrap, then plain decrements.
    up = 1'b0;
    step(1);
    check("down out0", int'(out0), 7);
    check("down wrap0", int'(wrap0), 1);
    check("sat leave out2", int'(out2), 3);
    check("sat leave sat2", int'(sat2), 0);
    for (int k = 6; k >= 4; k--) begin
      step(1);
      check($sformatf("down out0 %0d", k), int'(out0), k);
      check($sformatf("down wrap0 %0d", k), int'(wrap0), 0);
    end

    // Out-of-range load clamps, then wraps on the next up step.
    lv   = 4'd12;
    load = 1'b1;
    step(1);
    load = 1'b0;
    up   = 1'b1;
    check("load clamp out1", int'(out1), 9);
    check("load out0", int'(out0), 4);
    step(1);
    check("load wrap out1", int'(out1), 0);
    check("load wrap wrap1", int'(wrap1), 1);

    // Prescaler: every third enabled cycle; two idle cycles stretch the gap.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear out3", int'(out3), 0);
    step(2);
    check("pre early out3", int'(out3), 0);
    step(1);
    check("pre tick out3", int'(out3), 1);
    enable = 1'b0;
    step(2);
    check("pre frozen out3", int'(out3), 1);
    enable = 1'b1;
    step(2);
    check("pre resume out3", int'(out3), 1);
    step(1);
    check("pre second out3", int'(out3), 2);
    lv    = 4'd6;
    clear = 1'b1;
    load  = 1'b1;
    step(1);
    clear = 1'b0;
    load  = 1'b0;
    check("clr+load out3", int'(out3), 0);
    check("clr+load out0", int'(out0), 0);

    // Asynchronous reset mid-count, then restart from 0.
    step(5);
    check("pre-reset out0", int'(out0), 5);
    #1;
    reset = 1'b0;
    #1;
    check("async out0", int'(out0), 0);
    check("async out3", int'(out3), 0);
    step(2);
    reset = 1'b1;
    step(1);
    check("restart out0", int'(out0), 1);
    check("restart out3 a", int'(out3), 0);
    step(1);
    check("restart out3 b", int'(out3), 0);
    step(1);
    check("restart out3 c", int'(out3), 1);

    chk_en = 1'b0;
    step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
